mole_game_ctrl: RTL and testbench
=================================

# mole_game_ctrl

Game sequencer for the whack-a-mole datapath. Owns the round state machine, the 60 s countdown, mole spawn and timeout, and one-shot hit/miss judgement with a saturating score. Sits between the tick dividers, random generator and keypad scanner on the input side, and the VGA driver, seven-segment and dot-matrix score displays on the output side. Replaces the free-running position and the level-sensitive hit compare.

## Interface

Parameters:
- GAME_SECONDS, 60: round length in seconds (1..99).
- UP_MS, 1000: mole visible window in 1 kHz ticks.
- HIT_MS, 200: hit-flash duration in ticks.
- GAP_MS, 250: empty gap between moles in ticks.
- MAX_SCORE, 99: score saturation value.

Ports:
- clk, in, 1: 50 MHz system clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- inGame, in, 1: level; high = play requested.
- tick_1khz, in, 1: one-cycle strobe, 1 kHz.
- tick_1hz, in, 1: one-cycle strobe, 1 Hz.
- rnd, in, 4: current random value, sampled only at spawn.
- key_valid, in, 1: one-cycle strobe per debounced key press.
- key_code, in, 4: key index, valid with key_valid.
- position, out, 4: current mole hole 0..15.
- mole_up, out, 1: mole visible (UP or HIT_SHOW).
- hit_flash, out, 1: high in HIT_SHOW.
- hit_pulse, out, 1: one cycle per accepted hit.
- miss_pulse, out, 1: one cycle per wrong key or mole timeout.
- score, out, 7: hits this round, 0..MAX_SCORE.
- time_left, out, 7: seconds remaining.
- game_over, out, 1: high in OVER.

## Operation

- States: IDLE, SPAWN, UP, HIT_SHOW, GAP, OVER.
- IDLE: outputs quiescent. When inGame=1, go to SPAWN. On that transition, score clears to 0 and time_left loads GAME_SECONDS.
- SPAWN (1 cycle): position <= rnd. If rnd equals the previous position, use rnd+1 (4-bit wrap, so 15 goes to 0). Load the ms counter with UP_MS, then go to UP.
- UP:
  - key_valid with key_code==position: hit_pulse, score+1 saturating at MAX_SCORE, load HIT_MS, go to HIT_SHOW.
  - key_valid with a mismatching code: miss_pulse; stay in UP; the ms counter is unaffected.
  - ms counter expiry: miss_pulse, load GAP_MS, go to GAP.
- HIT_SHOW: on expiry, load GAP_MS and go to GAP. Keys are ignored.
- GAP: mole_up=0. On expiry, go to SPAWN. Keys are ignored.
- Countdown:
  - In SPAWN/UP/HIT_SHOW/GAP, each tick_1hz decrements time_left.
  - When time_left is 1 and a tick arrives, time_left goes to 0 and the state goes to OVER.
- OVER: game_over=1, mole_up=0. score and time_left are held. When inGame=0, go to IDLE.
- inGame=0 in any active state: go to IDLE next cycle. score and time_left are held for display.
- Only one hit per mole is possible, because HIT_SHOW ignores keys.

## Timing

- All outputs are registered.
- Reset values: state IDLE, position 0, mole_up 0, hit_flash 0, hit_pulse 0, miss_pulse 0, score 0, time_left GAME_SECONDS, game_over 0.
- Key latency: key_valid in cycle N gives hit_pulse/miss_pulse, the score update and the state change in cycle N+1.
- Spawn latency: SPAWN is one cycle. mole_up rises and the new position is valid together, one cycle after leaving GAP/IDLE.
- ms counter:
  - Decrements only on tick_1khz.
  - Expiry is the tick that takes it from 1 to 0.
  - Window lengths are therefore N ticks, with ±1 tick of phase jitter.
- Simultaneous events:
  - A matching key and the final tick_1hz in the same cycle: the hit is scored, then the state goes to OVER.
  - A matching key and UP expiry in the same cycle: the hit wins.
  - inGame=0 has priority over everything except rst.
- rst mid-round: next cycle all outputs take their reset values.
- hit_pulse and miss_pulse are never high in the same cycle.

## Structure

- Package mole_pkg holds:
  - the state enum;
  - the widths POS_W=4, SCORE_W=7, TIME_W=7;
  - the default timing constants.
- One sub-module, mole_ms_timer: loadable down counter, enable=tick_1khz, single-cycle expire output.
- Countdown, score and FSM stay in mole_game_ctrl.

## Test plan

- Reset, then inGame=1, rnd=5 -> SPAWN, then UP with position=5, mole_up=1, time_left=60, score=0.
- In UP with position=5: key 5 -> hit_pulse 1 cycle, score=1, hit_flash for 200 ticks, GAP for 250 ticks, then respawn. A second key 5 during HIT_SHOW -> no change.
- In UP with position=5: key 3 -> miss_pulse, still UP, score unchanged. No key for 1000 ticks -> miss_pulse, GAP.
- Repeat guard:
  - Previous position 15 and rnd=15 -> position=0.
  - Previous position 7 and rnd=7 -> position=8.
- Countdown end:
  - After 60 tick_1hz strobes -> game_over=1, mole_up=0, score held.
  - The final tick coinciding with a matching key -> score incremented, then OVER.
  - inGame=0 -> IDLE.
- Interrupts:
  - 100 hits -> score saturates at 99.
  - rst asserted in HIT_SHOW -> all outputs at reset values next cycle.
  - inGame dropped in UP -> IDLE next cycle.

Source files
------------

// File: rtl/mole_pkg.sv
// mole_pkg: shared states, widths and default timing for the whack-a-mole sequencer
package mole_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_UP, S_HIT, S_GAP, S_OVER} state_t;
    localparam int POS_W = 4;
    localparam int SCORE_W = 7;
    localparam int TIME_W = 7;
    localparam int MS_W = 16;
    localparam int unsigned DEF_GAME_SECONDS = 60;
    localparam int unsigned DEF_UP_MS = 1000;
    localparam int unsigned DEF_HIT_MS = 200;
    localparam int unsigned DEF_GAP_MS = 250;
    localparam int unsigned DEF_MAX_SCORE = 99;
endpackage

// File: rtl/mole_ms_timer.sv
// mole_ms_timer: loadable down counter stepping on enable; expire marks the 1 -> 0 step
module mole_ms_timer
    import mole_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [MS_W-1:0] load_val,
    output logic            expire
);
    logic [MS_W-1:0] cnt;
    assign expire = en && cnt == MS_W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - MS_W'(1);
    end
endmodule

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: round FSM, 1 Hz countdown, mole spawn/timeout and one-shot hit/miss scoring
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned GAME_SECONDS = DEF_GAME_SECONDS,
    parameter int unsigned UP_MS = DEF_UP_MS,
    parameter int unsigned HIT_MS = DEF_HIT_MS,
    parameter int unsigned GAP_MS = DEF_GAP_MS,
    parameter int unsigned MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inGame,
    input  logic               tick_1khz,
    input  logic               tick_1hz,
    input  logic [POS_W-1:0]   rnd,
    input  logic               key_valid,
    input  logic [POS_W-1:0]   key_code,
    output logic [POS_W-1:0]   position,
    output logic               mole_up,
    output logic               hit_flash,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_left,
    output logic               game_over
);
    state_t state, state_d;
    logic [POS_W-1:0] pos_d;
    logic [SCORE_W-1:0] score_d;
    logic [TIME_W-1:0] time_d;
    logic hit_d, miss_d, tmr_load, tmr_exp, active, hit;
    logic [MS_W-1:0] tmr_val;

    assign active = state inside {S_SPAWN, S_UP, S_HIT, S_GAP};
    assign hit = state == S_UP && key_valid && key_code == position;

    mole_ms_timer u_timer (
        .clk(clk),
        .rst(rst),
        .en(tick_1khz),
        .load(tmr_load),
        .load_val(tmr_val),
        .expire(tmr_exp)
    );

    always_comb begin
        state_d = state;
        pos_d = position;
        score_d = score;
        time_d = time_left;
        hit_d = 1'b0;
        miss_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val = MS_W'(GAP_MS);
        case (state)
            S_IDLE: if (inGame) begin
                state_d = S_SPAWN;
                score_d = '0;
                time_d = TIME_W'(GAME_SECONDS);
            end
            S_SPAWN: begin
                pos_d = (rnd == position) ? rnd + POS_W'(1) : rnd;
                tmr_load = 1'b1;
                tmr_val = MS_W'(UP_MS);
                state_d = S_UP;
            end
            S_UP: if (hit) begin
                hit_d = 1'b1;
                score_d = (score >= SCORE_W'(MAX_SCORE)) ? score : score + SCORE_W'(1);
                tmr_load = 1'b1;
                tmr_val = MS_W'(HIT_MS);
                state_d = S_HIT;
            end else if (tmr_exp) begin
                miss_d = 1'b1;
                tmr_load = 1'b1;
                state_d = S_GAP;
            end else miss_d = key_valid;
            S_HIT: if (tmr_exp) begin
                tmr_load = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: if (tmr_exp) state_d = S_SPAWN;
            S_OVER: if (!inGame) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // the final second overrides any mole transition, but a same-cycle hit still scores
        if (active && tick_1hz && time_left != '0) begin
            time_d = time_left - TIME_W'(1);
            if (time_left == TIME_W'(1)) state_d = S_OVER;
        end
        if (active && !inGame) begin
            state_d = S_IDLE;
            pos_d = position;
            score_d = score;
            time_d = time_left;
            hit_d = 1'b0;
            miss_d = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            position <= '0;
            score <= '0;
            time_left <= TIME_W'(GAME_SECONDS);
            hit_pulse <= 1'b0;
            miss_pulse <= 1'b0;
            mole_up <= 1'b0;
            hit_flash <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state <= state_d;
            position <= pos_d;
            score <= score_d;
            time_left <= time_d;
            hit_pulse <= hit_d;
            miss_pulse <= miss_d;
            mole_up <= state_d inside {S_UP, S_HIT};
            hit_flash <= state_d == S_HIT;
            game_over <= state_d == S_OVER;
        end
    end
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: directed vectors with hand-computed expectations for the mole sequencer
module tb_mole_game_ctrl;
    logic clk = 1'b0;
    logic rst, inGame, tick_1khz, tick_1hz, key_valid;
    logic [3:0] rnd, key_code, position;
    logic mole_up, hit_flash, hit_pulse, miss_pulse, game_over;
    logic [6:0] score, time_left;
    int n_checks = 0;
    int n_fail = 0;

    mole_game_ctrl dut (
        .clk(clk),
        .rst(rst),
        .inGame(inGame),
        .tick_1khz(tick_1khz),
        .tick_1hz(tick_1hz),
        .rnd(rnd),
        .key_valid(key_valid),
        .key_code(key_code),
        .position(position),
        .mole_up(mole_up),
        .hit_flash(hit_flash),
        .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse),
        .score(score),
        .time_left(time_left),
        .game_over(game_over)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic tick_sec();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic wait_mole(input logic lvl);
        int n = 0;
        while (mole_up !== lvl && n < 5000) begin
            step();
            n++;
        end
        if (mole_up !== lvl) check("wait_mole", int'(mole_up), int'(lvl));
    endtask

    task automatic next_mole();
        tick_1khz = 1'b1;
        wait_mole(1'b0);
        wait_mole(1'b1);
        tick_1khz = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_position"}, position, 0);
        check({tag, "_mole_up"}, mole_up, 0);
        check({tag, "_hit_flash"}, hit_flash, 0);
        check({tag, "_hit_pulse"}, hit_pulse, 0);
        check({tag, "_miss_pulse"}, miss_pulse, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_time_left"}, time_left, 60);
        check({tag, "_game_over"}, game_over, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        inGame = 1'b0;
        tick_1khz = 1'b0;
        tick_1hz = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        rnd = 4'd0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_outputs("reset");
        step();
        check("idle_mole_up", mole_up, 0);

        // start: SPAWN then UP at hole 5
        inGame = 1'b1;
        rnd = 4'd5;
        step();
        check("spawn_mole_up", mole_up, 0);
        step();
        check("up_position", position, 5);
        check("up_mole_up", mole_up, 1);
        check("up_time_left", time_left, 60);
        check("up_score", score, 0);

        press(4'd5);
        check("hit_pulse", hit_pulse, 1);
        check("hit_miss_pulse", miss_pulse, 0);
        check("hit_score", score, 1);
        check("hit_flash", hit_flash, 1);
        press(4'd5);
        check("rehit_pulse", hit_pulse, 0);
        check("rehit_score", score, 1);

        tick_1khz = 1'b1;
        n = 0;
        while (hit_flash && n < 5000) begin step(); n++; end
        check("hit_window", n, 200);
        check("gap_mole_up", mole_up, 0);
        n = 0;
        while (!mole_up && n < 5000) begin step(); n++; end
        check("gap_respawn", n, 251);
        check("repeat_5_to_6", position, 6);
        tick_1khz = 1'b0;

        press(4'd3);
        check("miss_pulse", miss_pulse, 1);
        check("miss_hit_pulse", hit_pulse, 0);
        check("miss_still_up", mole_up, 1);
        check("miss_score", score, 1);
        step();
        check("miss_pulse_one", miss_pulse, 0);
        tick_1khz = 1'b1;
        n = 0;
        while (!miss_pulse && n < 5000) begin step(); n++; end
        check("up_timeout", n, 1000);
        check("timeout_gap", mole_up, 0);
        check("timeout_score", score, 1);

        rnd = 4'd15;
        wait_mole(1'b1);
        tick_1khz = 1'b0;
        check("spawn_15", position, 15);
        press(4'd15);
        next_mole();
        check("repeat_15_to_0", position, 0);
        rnd = 4'd7;
        press(4'd0);
        next_mole();
        check("spawn_7", position, 7);
        press(4'd7);
        next_mole();
        check("repeat_7_to_8", position, 8);
        check("score_4", score, 4);

        // countdown ending on a matching key
        tick_sec();
        check("time_59", time_left, 59);
        repeat (58) tick_sec();
        check("time_1", time_left, 1);
        key_valid = 1'b1;
        key_code = 4'd8;
        tick_1hz = 1'b1;
        step();
        key_valid = 1'b0;
        tick_1hz = 1'b0;
        check("final_hit_score", score, 5);
        check("final_game_over", game_over, 1);
        check("final_mole_up", mole_up, 0);
        check("final_time", time_left, 0);
        tick_sec();
        check("over_hold_time", time_left, 0);
        check("over_hold", game_over, 1);
        inGame = 1'b0;
        step();
        check("over_idle", game_over, 0);
        check("idle_score_held", score, 5);

        // score saturation
        inGame = 1'b1;
        rnd = 4'd3;
        step();
        step();
        check("round2_score", score, 0);
        check("round2_time", time_left, 60);
        for (int i = 0; i < 100; i++) begin
            press(position);
            if (i == 98) check("score_99", score, 99);
            if (i == 99) check("score_sat", score, 99);
            next_mole();
        end
        repeat (60) tick_sec();
        check("sat_over", game_over, 1);
        check("sat_mole_up", mole_up, 0);
        check("sat_score_held", score, 99);
        check("sat_time", time_left, 0);
        inGame = 1'b0;
        step();

        // reset during HIT_SHOW
        inGame = 1'b1;
        step();
        step();
        press(position);
        check("pre_rst_flash", hit_flash, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_hit");

        // inGame dropped in UP
        step();
        step();
        check("drop_up", mole_up, 1);
        press(position ^ 4'd1);
        check("drop_miss", miss_pulse, 1);
        inGame = 1'b0;
        step();
        check("drop_mole_up", mole_up, 0);
        check("drop_miss_pulse", miss_pulse, 0);
        check("drop_score", score, 0);
        check("drop_time", time_left, 60);
        check("drop_game_over", game_over, 0);
        step();
        check("drop_stays_idle", mole_up, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
